// File: rtl/bits_to_string_ser.sv
// Packed word -> ASCII byte stream, MSB byte first, NUL bytes above the first character skipped.
// Interior NULs are skipped only when BITS_TO_STRING_DROP_INNER_NUL_EN is defined.
module bits_to_string_ser #(
  parameter int NBYTES = 11,
  parameter int CNTW   = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  done,
  output logic [CNTW-1:0]       count
);

  localparam int PW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef BITS_TO_STRING_DROP_INNER_NUL_EN
  localparam bit DROP_INNER = 1'b1;
`else
  localparam bit DROP_INNER = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  state_t                state_q, state_d;
  logic [8*NBYTES-1:0]   sr_q, sr_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_char_q, out_char_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic [CNTW-1:0]       count_q, count_d;

  logic [NBYTES-1:0]     nz_in, qual_in, qual_sr;
  logic [PW-1:0]         hi_in, nxt_sr;
  logic                  last_in, last_sr;

  // Highest set index strictly below lim; callers only use it when a hit exists.
  function automatic logic [PW-1:0] hi_below(input logic [NBYTES-1:0] q, input int lim);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (q[i] && (i < lim)) idx = PW'(i);
    end
    return idx;
  endfunction

  function automatic logic any_below(input logic [NBYTES-1:0] q, input int lim);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (q[i] && (i < lim)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_at(input logic [8*NBYTES-1:0] d, input logic [PW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (PW'(i) == idx) b = d[i*8 +: 8];
    end
    return b;
  endfunction

  // Once the first character is found, the non-dropping build emits every lower byte.
  always_comb begin
    nz_in   = '0;
    qual_sr = '0;
    for (int i = 0; i < NBYTES; i++) begin
      nz_in[i]   = |in_data[i*8 +: 8];
      qual_sr[i] = DROP_INNER ? (|sr_q[i*8 +: 8]) : 1'b1;
    end
    qual_in = DROP_INNER ? nz_in : '1;
    hi_in   = hi_below(nz_in, NBYTES);
    last_in = !any_below(qual_in, int'(hi_in));
    nxt_sr  = hi_below(qual_sr, int'(ptr_q));
    last_sr = !any_below(qual_sr, int'(nxt_sr));
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          sr_d       = in_data;
          count_d    = '0;
          if (|nz_in) begin
            state_d     = EMIT;
            ptr_d       = hi_in;
            out_valid_d = 1'b1;
            out_char_d  = byte_at(in_data, hi_in);
            out_last_d  = last_in;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        in_ready_d = 1'b0;
        if (out_valid_q && out_ready) begin
          count_d = count_q + CNTW'(1);
          if (out_last_q) begin
            state_d     = FIN;
            out_valid_d = 1'b0;
            out_char_d  = 8'h00;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            ptr_d      = nxt_sr;
            out_char_d = byte_at(sr_q, nxt_sr);
            out_last_d = last_sr;
          end
        end
      end
      FIN: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      ptr_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule
